// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants for the IF stage.
package riscv_pkg;

   typedef enum logic [1:0] {BOOT, FETCH, WAIT, SQUASH} fetch_state_e;

   localparam int INSTR_BYTES    = 4;
   localparam int REDIRECT_CNT_W = 16;

endpackage

// File: rtl/pc_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module pc_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   localparam logic [W-1:0] ONE = W'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage PC owner: fetch requests, EX redirects and younger-stage squash.
// Build option MISALIGN_TRAP_EN: misaligned redirect targets trap instead of being truncated.
//
// state  | meaning
// BOOT   | first cycle out of reset, no request; a redirect here is parked as pending
// FETCH  | request PC; advance when memory returns and IF/ID is not stalled
// WAIT   | memory not ready, address held until it returns
// SQUASH | one cycle after a redirect; flushes asserted, target already on the bus
module pc_fetch_unit
   import riscv_pkg::*;
#(
   parameter int              PC_W     = 9,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      PcSel,
   input  logic [31:0]               BrPC,
   input  logic                      Stall,
   input  logic                      ImemReady,
   output logic                      ImemReq,
   output logic [PC_W-1:0]           ImemAddr,
   output logic [PC_W-1:0]           Cur_PC,
   output logic                      FetchValid,
   output logic                      FlushIfId,
   output logic                      FlushIdEx,
   output logic [REDIRECT_CNT_W-1:0] RedirectCnt
`ifdef MISALIGN_TRAP_EN
   ,
   output logic                      MisalignTrap
`endif
);

   fetch_state_e    state, state_nxt;
   logic [PC_W-1:0] pc, pc_nxt;
   logic [PC_W-1:0] cur_pc, cur_pc_nxt;
   logic [PC_W-1:0] pend_pc, pend_pc_nxt;
   logic [PC_W-1:0] target;
   logic            pend_v, pend_v_nxt;
   logic            fetch_valid, fetch_valid_nxt;
   logic            flush, flush_nxt;
   logic            redirect;
   logic            cnt_inc;
   logic            brpc_unused;
`ifdef MISALIGN_TRAP_EN
   logic            trap, trap_nxt;
`endif

   assign brpc_unused = ^BrPC[31:PC_W];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= BOOT;
         pc          <= RESET_PC;
         cur_pc      <= RESET_PC;
         pend_v      <= 1'b0;
         pend_pc     <= '0;
         fetch_valid <= 1'b0;
         flush       <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         trap        <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         cur_pc      <= cur_pc_nxt;
         pend_v      <= pend_v_nxt;
         pend_pc     <= pend_pc_nxt;
         fetch_valid <= fetch_valid_nxt;
         flush       <= flush_nxt;
`ifdef MISALIGN_TRAP_EN
         trap        <= trap_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      cur_pc_nxt      = cur_pc;
      pend_v_nxt      = pend_v;
      pend_pc_nxt     = pend_pc;
      fetch_valid_nxt = fetch_valid;
      flush_nxt       = 1'b0;
      cnt_inc         = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap_nxt        = 1'b0;
`endif
      // A live PcSel overrides a redirect parked during BOOT.
      redirect = (state != BOOT) && (PcSel || pend_v);
      target   = PcSel ? BrPC[PC_W-1:0] : pend_pc;

      if (redirect) begin
         state_nxt       = SQUASH;
         fetch_valid_nxt = 1'b0;
         flush_nxt       = 1'b1;
         pend_v_nxt      = 1'b0;
`ifdef MISALIGN_TRAP_EN
         if (target[1:0] != 2'b00) begin
            trap_nxt = 1'b1;
         end else begin
            pc_nxt  = target;
            cnt_inc = 1'b1;
         end
`else
         pc_nxt  = {target[PC_W-1:2], 2'b00};
         cnt_inc = 1'b1;
`endif
      end else begin
         case (state)
            BOOT: begin
               state_nxt       = FETCH;
               fetch_valid_nxt = 1'b0;
               if (PcSel) begin
                  pend_v_nxt  = 1'b1;
                  pend_pc_nxt = BrPC[PC_W-1:0];
               end
            end
            FETCH, WAIT: begin
               if (!Stall) begin
                  if (ImemReady) begin
                     state_nxt       = FETCH;
                     fetch_valid_nxt = 1'b1;
                     cur_pc_nxt      = pc;
                     pc_nxt          = pc + PC_W'(INSTR_BYTES);
                  end else begin
                     state_nxt       = WAIT;
                     fetch_valid_nxt = 1'b0;
                  end
               end
            end
            SQUASH: begin
               state_nxt       = FETCH;
               fetch_valid_nxt = 1'b0;
            end
            default: state_nxt = BOOT;
         endcase
      end
   end

   pc_sat_counter #(.W(REDIRECT_CNT_W)) u_redirect_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (cnt_inc),
      .count (RedirectCnt)
   );

   assign ImemReq    = (state != BOOT);
   assign ImemAddr   = pc;
   assign Cur_PC     = cur_pc;
   assign FetchValid = fetch_valid;
   assign FlushIfId  = flush;
   assign FlushIdEx  = flush;
`ifdef MISALIGN_TRAP_EN
   assign MisalignTrap = trap;
`endif

endmodule
